// File: rtl/jram_loader_if.sv
// jram_loader_if: stream-in and jRAM control bundle for the jRAM loader.
// The loader connects through the slave modport; the driving side uses master.
interface jram_loader_if #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
);
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic [DW-1:0] in_data;
   logic          in_valid;
   logic          in_ready;
   logic [AW-1:0] bas;
   logic          wsa;
   logic [DW-1:0] bis;
   logic          ws;
   logic          we;
   logic [DW-1:0] bos;
   logic          busy;
   logic          done;
   logic          err;

   modport slave (
      input  start, base, len, in_data, in_valid, bos,
      output in_ready, bas, wsa, bis, ws, we, busy, done, err
   );

   modport master (
      output start, base, len, in_data, in_valid, bos,
      input  in_ready, bas, wsa, bis, ws, we, busy, done, err
   );
endinterface

// File: rtl/jram_loader.sv
// jram_loader: writes a valid/ready byte stream into consecutive jRAM cells.
// Per byte: load MAR through bas/wsa, then strobe data through bis/ws.
// Optional read-back check of each cell is enabled by JRAM_LOADER_VERIFY_EN.
module jram_loader #(
   parameter int unsigned AW = 8,
   parameter int unsigned DW = 8
) (
   input logic         clk,
   input logic         reset,
   jram_loader_if.slave bus
);
   localparam int unsigned CW = AW + 1;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_SETA   = 3'd2,
      S_WRITE  = 3'd3,
      S_VERIFY = 3'd4,
      S_FIN    = 3'd5
   } state_t;

   state_t        state_q;
   logic [AW-1:0] addr_q;
   logic [CW-1:0] cnt_q;
   logic [AW-1:0] bas_q;
   logic [DW-1:0] bis_q;
   logic          wsa_q;
   logic          ws_q;
   logic          in_ready_q;
   logic          busy_q;
   logic          done_q;
`ifdef JRAM_LOADER_VERIFY_EN
   logic          we_q;
   logic          err_q;
`endif

   // Sequencer: one state per jRAM control phase, every output registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         addr_q     <= '0;
         cnt_q      <= '0;
         bas_q      <= '0;
         bis_q      <= '0;
         wsa_q      <= 1'b0;
         ws_q       <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
`ifdef JRAM_LOADER_VERIFY_EN
         we_q       <= 1'b0;
         err_q      <= 1'b0;
`endif
      end else begin
         // Strobes and done are single-cycle pulses unless re-armed below.
         wsa_q  <= 1'b0;
         ws_q   <= 1'b0;
         done_q <= 1'b0;
`ifdef JRAM_LOADER_VERIFY_EN
         we_q   <= 1'b0;
`endif
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  addr_q <= bus.base;
                  cnt_q  <= bus.len;
                  busy_q <= 1'b1;
`ifdef JRAM_LOADER_VERIFY_EN
                  err_q  <= 1'b0;
`endif
                  if (bus.len == '0) begin
                     state_q <= S_FIN;
                  end else begin
                     state_q    <= S_FETCH;
                     in_ready_q <= 1'b1;
                  end
               end
            end
            S_FETCH: begin
               if (bus.in_valid) begin
                  bis_q      <= bus.in_data;
                  bas_q      <= addr_q;
                  in_ready_q <= 1'b0;
                  wsa_q      <= 1'b1;
                  state_q    <= S_SETA;
               end
            end
            S_SETA: begin
               ws_q    <= 1'b1;
               state_q <= S_WRITE;
            end
            S_WRITE: begin
               addr_q <= addr_q + AW'(1);
               cnt_q  <= cnt_q - CW'(1);
`ifdef JRAM_LOADER_VERIFY_EN
               we_q    <= 1'b1;
               state_q <= S_VERIFY;
`else
               if (cnt_q == CW'(1)) begin
                  state_q <= S_FIN;
               end else begin
                  state_q    <= S_FETCH;
                  in_ready_q <= 1'b1;
               end
`endif
            end
`ifdef JRAM_LOADER_VERIFY_EN
            S_VERIFY: begin
               if (bus.bos != bis_q) err_q <= 1'b1;
               if (cnt_q == '0) begin
                  state_q <= S_FIN;
               end else begin
                  state_q    <= S_FETCH;
                  in_ready_q <= 1'b1;
               end
            end
`endif
            S_FIN: begin
               done_q  <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.bas      = bas_q;
   assign bus.bis      = bis_q;
   assign bus.wsa      = wsa_q;
   assign bus.ws       = ws_q;
   assign bus.in_ready = in_ready_q;
   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
`ifdef JRAM_LOADER_VERIFY_EN
   assign bus.we       = we_q;
   assign bus.err      = err_q;
`else
   // Without read-back the cell enable and error flag are constant and bos is ignored.
   logic unused_bos;
   assign unused_bos = ^bus.bos;
   assign bus.we     = 1'b0;
   assign bus.err    = 1'b0;
`endif
endmodule
